dmem_responder: RTL

//  Memory-side responder for the LSQ <-> data-memory request protocol (addr/data/rw/id/valid in; data/id/ready/stall out).

---
 rtl/dmem_responder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: in-order memory-side responder for LSQ data requests.
// Ports: clk, rst (async high); request addr_in/data_in/rw_in/id_in/valid_in;
// reply data_out/id_out/ready_out (one pulse per request); stall_out (FIFO full).
// Optional: define DMEM_VARLAT_EN to give odd word indices LATENCY+2 cycles.
module dmem_responder #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3,
  parameter int AW      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        rw_in,
  input  logic [3:0]  id_in,
  input  logic        valid_in,
  output logic [31:0] data_out,
  output logic [3:0]  id_out,
  output logic        ready_out,
  output logic        stall_out
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int CNTW = $clog2(LATENCY + 2) + 1;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [31:0]   data;
    logic          rw;
    logic [3:0]    id;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  req_t          fifo [DEPTH];
  logic [31:0]   mem  [2**AW];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_nxt;
  logic [CW-1:0] count;
  state_t        state;
  logic [CNTW-1:0] cnt;

  req_t          new_req;
  req_t          head;
  logic          push;
  logic          pop;
  logic          access;
  logic          more;
  logic [CNTW-1:0] cnt_head;
  logic [CNTW-1:0] cnt_next;

  logic unused_addr;
  assign unused_addr = ^{addr_in[1:0], addr_in[31:AW+2]};

  assign stall_out = (count == CW'(DEPTH));
  assign push      = valid_in && !stall_out;
  assign pop       = (state == RESP);
  assign access    = (state == WAIT) && (cnt == CNTW'(1));
  assign rd_nxt    = rd_ptr + 1'b1;
  assign head      = fifo[rd_ptr];

  // After the pop, something is still pending if another entry sits
  // behind the head or a request is being accepted on this edge.
  assign more = (count > CW'(1)) || push;

  always_comb begin
    new_req      = '0;
    new_req.idx  = addr_in[AW+1:2];
    new_req.data = data_in;
    new_req.rw   = rw_in;
    new_req.id   = id_in;
  end

`ifdef DMEM_VARLAT_EN
  logic [AW-1:0] nxt_idx;

  // The entry that becomes head after the pop: either the one behind
  // the current head, or the request arriving now into an empty slot.
  assign nxt_idx  = (count > CW'(1)) ? fifo[rd_nxt].idx
                                     : addr_in[AW+1:2];
  assign cnt_head = head.idx[0] ? CNTW'(LATENCY + 1)
                                : CNTW'(LATENCY - 1);
  assign cnt_next = nxt_idx[0] ? CNTW'(LATENCY + 1)
                               : CNTW'(LATENCY - 1);
`else
  logic unused_nxt;
  assign unused_nxt = ^rd_nxt;
  assign cnt_head   = CNTW'(LATENCY - 1);
  assign cnt_next   = CNTW'(LATENCY - 1);
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= new_req;
    end
  end

  // Array contents survive reset; state is IDLE while rst is held,
  // so no write can occur during reset.
  always_ff @(posedge clk) begin
    if (access && head.rw) begin
      mem[head.idx] <= head.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_nxt;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      data_out  <= '0;
      id_out    <= '0;
      ready_out <= 1'b0;
    end else begin
      ready_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            state <= WAIT;
            cnt   <= cnt_head;
          end
        end
        WAIT: begin
          if (cnt == CNTW'(1)) begin
            ready_out <= 1'b1;
            id_out    <= head.id;
            data_out  <= head.rw ? 32'h0 : mem[head.idx];
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (more) begin
            state <= WAIT;
            cnt   <= cnt_next;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
